canny_frame_sequencer: RTL and testbench

Frame-level controller for the canny edge pipeline. It gates the source pixel FIFO into the first pipeline stage so that exactly WIDTH*HEIGHT pixels are released per frame. It counts pixels accepted at the pipeline sink and, once a frame has fully drained, starts the Hough stage and waits for it to finish. It supports multi-frame runs, abort, and a stall watchdog.

---
 rtl/canny_pkg.sv | 18 +
 rtl/seq_watchdog.sv | 30 +++
 rtl/canny_frame_sequencer.sv | 172 +++++++++++++++++
 tb/tb_canny_frame_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared types and sizing helpers for the canny frame-level control blocks.
package canny_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        HOUGH_WAIT,
        ERROR
    } seq_state_t;

    typedef logic [7:0] pixel_t;

    function automatic int pixel_count(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Stall watchdog: counts enabled cycles since the last kick and flags expiry
// on the cycle that completes TIMEOUT_CYCLES idle cycles.
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = enable & ~kick & (count == CW'(TIMEOUT_CYCLES - 1));

    // Leaving the enabled states drops the count, so every fresh entry starts at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (kick || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame sequencer: meters WIDTH*HEIGHT pixels into the pipeline per frame,
// waits for the sink to drain, then hands off to the Hough stage.
module canny_frame_sequencer
    import canny_pkg::*;
#(
    parameter int WIDTH          = 1280,
    parameter int HEIGHT         = 720,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] num_frames,
    input  logic       abort,
    output logic       busy,
    output logic [7:0] frame_idx,
    output logic       frame_done,
    output logic       all_done,
    output logic       error,
    input  logic       src_empty,
    input  pixel_t     src_dout,
    output logic       src_rd_en,
    output logic       pipe_empty,
    output pixel_t     pipe_dout,
    input  logic       pipe_rd_en,
    input  logic       sink_wr_en,
    input  logic       sink_full,
    output logic       hough_start,
    input  logic       hough_done,
    output seq_state_t seq_state
);

    localparam int PIXEL_COUNT = pixel_count(WIDTH, HEIGHT);
    localparam int CNT_W       = $clog2(PIXEL_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXEL_COUNT);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] in_cnt, in_cnt_nxt, out_cnt, out_cnt_nxt;
    logic [7:0]       frames, frames_nxt, frame_idx_nxt;
    logic             hough_start_nxt, frame_done_nxt, all_done_nxt;
    logic             gate_open, in_accept, out_accept;
    logic             wd_enable, wd_expired;

    // FIFO-style handshakes: a word moves in a cycle where the reader's rd_en is
    // high and empty is low; a sink write lands where wr_en is high and full is low.
    assign gate_open  = (state == STREAM);
    assign pipe_empty = src_empty | ~gate_open;
    assign src_rd_en  = pipe_rd_en & gate_open & ~src_empty;
    assign pipe_dout  = src_dout;
    assign in_accept  = pipe_rd_en & ~pipe_empty;
    assign out_accept = sink_wr_en & ~sink_full;

    assign busy      = (state != IDLE);
    assign error     = (state == ERROR);
    assign seq_state = state;
    assign wd_enable = (state == STREAM) || (state == DRAIN);

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .enable (wd_enable),
        .kick   (in_accept | out_accept),
        .expired(wd_expired)
    );

    always_comb begin
        state_nxt       = state;
        in_cnt_nxt      = in_cnt;
        out_cnt_nxt     = out_cnt;
        frames_nxt      = frames;
        frame_idx_nxt   = frame_idx;
        hough_start_nxt = 1'b0;
        frame_done_nxt  = 1'b0;
        all_done_nxt    = 1'b0;

        if (abort) begin
            state_nxt     = IDLE;
            in_cnt_nxt    = '0;
            out_cnt_nxt   = '0;
            frame_idx_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_accept) begin
                        state_nxt = ERROR;
                    end else if (start && (num_frames != 8'd0)) begin
                        state_nxt     = STREAM;
                        frames_nxt    = num_frames;
                        frame_idx_nxt = '0;
                        in_cnt_nxt    = '0;
                        out_cnt_nxt   = '0;
                    end
                end
                STREAM: begin
                    if (in_accept)  in_cnt_nxt  = in_cnt + 1'b1;
                    if (out_accept) out_cnt_nxt = out_cnt + 1'b1;
                    if (wd_expired) begin
                        state_nxt = ERROR;
                    end else if (out_accept && (out_cnt_nxt == LAST)) begin
                        // Sink finished while the gate is still open: only legal if
                        // the last input pixel is being taken in the same cycle.
                        if (in_cnt_nxt == LAST) begin
                            state_nxt       = HOUGH_WAIT;
                            hough_start_nxt = 1'b1;
                        end else begin
                            state_nxt = ERROR;
                        end
                    end else if (in_accept && (in_cnt_nxt == LAST)) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_accept) out_cnt_nxt = out_cnt + 1'b1;
                    if (wd_expired) begin
                        state_nxt = ERROR;
                    end else if (out_accept && (out_cnt_nxt == LAST)) begin
                        state_nxt       = HOUGH_WAIT;
                        hough_start_nxt = 1'b1;
                    end
                end
                HOUGH_WAIT: begin
                    // hough_start is high exactly in the entry cycle, so it masks hough_done there.
                    if (out_accept) begin
                        state_nxt = ERROR;
                    end else if (hough_done && !hough_start) begin
                        frame_done_nxt = 1'b1;
                        if (frame_idx == frames - 8'd1) begin
                            state_nxt    = IDLE;
                            all_done_nxt = 1'b1;
                        end else begin
                            state_nxt     = STREAM;
                            frame_idx_nxt = frame_idx + 8'd1;
                            in_cnt_nxt    = '0;
                            out_cnt_nxt   = '0;
                        end
                    end
                end
                ERROR: begin
                    state_nxt = ERROR;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            frames      <= '0;
            frame_idx   <= '0;
            hough_start <= 1'b0;
            frame_done  <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_cnt      <= in_cnt_nxt;
            out_cnt     <= out_cnt_nxt;
            frames      <= frames_nxt;
            frame_idx   <= frame_idx_nxt;
            hough_start <= hough_start_nxt;
            frame_done  <= frame_done_nxt;
            all_done    <= all_done_nxt;
        end
    end

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Directed bench for canny_frame_sequencer with a source FIFO model, a delayed
// pipeline model and a pixel scoreboard on the pass-through data path.
module tb_canny_frame_sequencer;
    import canny_pkg::*;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int TO   = 64;
    localparam int NPIX = W * H;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_frames = 8'd0;
    logic       abort = 1'b0;
    logic       busy, frame_done, all_done, error, src_rd_en, pipe_empty, hough_start;
    logic [7:0] frame_idx;
    logic       src_empty = 1'b1;
    pixel_t     src_dout = 8'h00;
    pixel_t     pipe_dout;
    logic       pipe_rd_en = 1'b0;
    logic       sink_wr_en = 1'b0;
    logic       sink_full = 1'b0;
    logic       hough_done = 1'b0;
    seq_state_t seq_state;

    always #5 clock = ~clock;

    canny_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .num_frames(num_frames),
        .abort(abort), .busy(busy), .frame_idx(frame_idx), .frame_done(frame_done),
        .all_done(all_done), .error(error), .src_empty(src_empty), .src_dout(src_dout),
        .src_rd_en(src_rd_en), .pipe_empty(pipe_empty), .pipe_dout(pipe_dout),
        .pipe_rd_en(pipe_rd_en), .sink_wr_en(sink_wr_en), .sink_full(sink_full),
        .hough_start(hough_start), .hough_done(hough_done), .seq_state(seq_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    int   pend = 0;
    logic [2:0] dl = 3'b000;
    logic pop_pending = 1'b0, in_acc = 1'b0, out_acc = 1'b0, force_wr = 1'b0, bp_en = 1'b0;
    int   rd_count = 0, out_count = 0, hs_count = 0;
    int   last_acc_cyc = 0, last_out_cyc = 0, hs_cyc = 0;
    bit   found;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh_src();
        src_empty = (src_q.size() == 0);
        src_dout  = src_empty ? 8'h00 : src_q[0];
    endtask

    // Advance one clock: update models just after the edge, sample at the falling edge.
    task automatic cycle();
        logic [7:0] e;
        @(posedge clock);
        #1;
        cyc++;
        if (pop_pending && src_q.size() > 0) void'(src_q.pop_front());
        if (out_acc && pend > 0) pend--;
        if (dl[2]) pend++;
        dl = {dl[1:0], in_acc};
        refresh_src();
        sink_wr_en = (pend > 0) | force_wr;
        sink_full  = bp_en & cyc[0];
        @(negedge clock);
        in_acc      = pipe_rd_en & ~pipe_empty;
        out_acc     = sink_wr_en & ~sink_full;
        pop_pending = src_rd_en;
        if (src_rd_en) rd_count++;
        if (in_acc) begin
            last_acc_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("exp_q_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pipe_dout", 32'(pipe_dout), 32'(e));
            end
        end
        if (out_acc) begin
            out_count++;
            last_acc_cyc = cyc;
            last_out_cyc = cyc;
        end
        if (hough_start) begin
            hs_count++;
            hs_cyc = cyc;
        end
    endtask

    task automatic load_pixels(input int n);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            p = 8'($urandom_range(0, 255));
            src_q.push_back(p);
            exp_q.push_back(p);
        end
        refresh_src();
    endtask

    task automatic flush_models();
        src_q.delete();
        exp_q.delete();
        pend = 0;
        dl = 3'b000;
        in_acc = 1'b0;
        out_acc = 1'b0;
        pop_pending = 1'b0;
        force_wr = 1'b0;
        refresh_src();
        rd_count = 0;
        out_count = 0;
        hs_count = 0;
    endtask

    task automatic kick_start(input logic [7:0] n);
        num_frames = n;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_hough(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (hough_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("hough_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_frame(input bit last);
        repeat (4) cycle();
        hough_done = 1'b1;
        cycle();
        hough_done = 1'b0;
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("all_done_with_frame", 32'(all_done), 32'(last));
        check("busy_after_frame", 32'(busy), 32'(!last));
        cycle();
        check("frame_done_one_cycle", 32'(frame_done), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_src_rd_en"}, 32'(src_rd_en), 32'd0);
        check({tag, "_pipe_empty"}, 32'(pipe_empty), 32'd1);
        check({tag, "_hough_start"}, 32'(hough_start), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_frame_idx"}, 32'(frame_idx), 32'd0);
        check({tag, "_state"}, 32'(seq_state), 32'(IDLE));
    endtask

    task automatic run_clean_frame(input string tag);
        load_pixels(NPIX);
        kick_start(8'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_hough(200, found);
        check({tag, "_reads"}, 32'(rd_count), 32'(NPIX));
        check({tag, "_writes"}, 32'(out_count), 32'(NPIX));
        check({tag, "_hs_latency"}, 32'(hs_cyc - last_out_cyc), 32'd1);
        finish_frame(1'b1);
        check({tag, "_hs_count"}, 32'(hs_count), 32'd1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        check_idle("reset");
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_all_done", 32'(all_done), 32'd0);
        reset = 1'b1;
        pipe_rd_en = 1'b1;
        repeat (2) cycle();

        // Start with zero frames is ignored
        kick_start(8'd0);
        cycle();
        check("zero_frames_busy", 32'(busy), 32'd0);

        // Single frame with surplus pixels queued
        flush_models();
        load_pixels(20);
        kick_start(8'd1);
        check("single_busy", 32'(busy), 32'd1);
        check("single_frame_idx", 32'(frame_idx), 32'd0);
        wait_hough(200, found);
        check("single_reads", 32'(rd_count), 32'(NPIX));
        check("single_writes", 32'(out_count), 32'(NPIX));
        check("single_hs_latency", 32'(hs_cyc - last_out_cyc), 32'd1);
        finish_frame(1'b1);
        repeat (3) cycle();
        check("single_reads_final", 32'(rd_count), 32'(NPIX));
        check("single_hs_count", 32'(hs_count), 32'd1);
        check("single_src_left", 32'(src_q.size()), 32'd8);

        // Three-frame run; the first frame also gets hough_done in its entry cycle
        flush_models();
        load_pixels(3 * NPIX);
        kick_start(8'd3);
        for (int f = 0; f < 3; f++) begin
            wait_hough(200, found);
            check("multi_frame_idx", 32'(frame_idx), 32'(f));
            if (f == 0) begin
                hough_done = 1'b1;
                cycle();
                hough_done = 1'b0;
                cycle();
                check("entry_done_ignored", 32'(frame_done), 32'd0);
                check("entry_done_busy", 32'(busy), 32'd1);
            end
            finish_frame(f == 2);
        end
        check("multi_hs_count", 32'(hs_count), 32'd3);
        check("multi_reads", 32'(rd_count), 32'(3 * NPIX));
        check("multi_writes", 32'(out_count), 32'(3 * NPIX));

        // Sink backpressure on alternate cycles
        flush_models();
        bp_en = 1'b1;
        run_clean_frame("backpressure");
        bp_en = 1'b0;
        sink_full = 1'b0;

        // Source stall after 7 pixels trips the watchdog
        flush_models();
        load_pixels(7);
        kick_start(8'd1);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (error) begin
                found = 1'b1;
                break;
            end
        end
        check("stall_error_seen", 32'(found), 32'd1);
        check("stall_latency", 32'(cyc - last_acc_cyc), 32'(TO + 1));
        check("stall_writes", 32'(out_count), 32'd7);
        repeat (3) cycle();
        check("stall_error_sticky", 32'(error), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_gate_closed", 32'(pipe_empty), 32'd1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check_idle("abort");

        // Overrun: stray sink write while waiting for Hough
        flush_models();
        load_pixels(NPIX);
        kick_start(8'd1);
        wait_hough(200, found);
        force_wr = 1'b1;
        cycle();
        force_wr = 1'b0;
        check("overrun_not_yet", 32'(error), 32'd0);
        cycle();
        check("overrun_error", 32'(error), 32'd1);
        check("overrun_state", 32'(seq_state), 32'(ERROR));
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check_idle("overrun_abort");

        // Asynchronous reset in the middle of a frame
        flush_models();
        load_pixels(NPIX);
        kick_start(8'd1);
        for (int i = 0; i < 100 && rd_count < 5; i++) cycle();
        check("midreset_reads", 32'(rd_count), 32'd5);
        reset = 1'b0;
        #1;
        check_idle("midreset");
        flush_models();
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        run_clean_frame("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL tb_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
